// File: rtl/storage_sequencer.sv
// storage_sequencer: per-tick frame scheduler for the board storage block.
// Runs up to four move slots (two tanks, two projectiles), then a full RAM
// rebuild scan, then returns storage to read mode for the display.
// Optional feature: define STORAGE_SEQ_ROUND_ROBIN_EN to alternate which
// tank's slot pair runs first on successive frames.
module storage_sequencer #(
  parameter int GRID_CELLS = 256,
  parameter int SLOT_LEN   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       p1_req,
  input  logic [1:0] p1_dir,
  input  logic       p1_fire,
  input  logic       p2_req,
  input  logic [1:0] p2_dir,
  input  logic       p2_fire,
  input  logic       wall_q,
  output logic [7:0] wall_addr,
  output logic [3:0] st_mode,
  output logic [7:0] st_address,
  output logic [7:0] st_data,
  output logic       st_load_out,
  output logic       st_has_wall,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int            CW        = $clog2(SLOT_LEN);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] LOAD_CYC  = CW'(1);
  localparam logic [7:0]    ADDR_LAST = 8'(GRID_CELLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SLOT_A,
    SLOT_B,
    SLOT_C,
    SLOT_D,
    SCAN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  // Pending requests indexed by slot kind: 0 tank1, 1 proj1, 2 tank2, 3 proj2.
  logic [3:0]    pend_q, pend_d;
  logic [1:0]    dir1_q, dir1_d, dir2_q, dir2_d;
  logic [1:0]    fdir1_q, fdir1_d, fdir2_q, fdir2_d;
  logic          prio_q, prio_d;

  logic          in_slot;
  logic [1:0]    cur_pos;
  logic [1:0]    cur_kind;
  logic [1:0]    slot_dir;

  // The priority bit swaps the tank1 pair with the tank2 pair.
  function automatic logic [1:0] kind_of(input logic [1:0] pos, input logic prio);
    return pos ^ {prio, 1'b0};
  endfunction

  function automatic logic is_slot(input state_t s);
    return (s == SLOT_A) || (s == SLOT_B) || (s == SLOT_C) || (s == SLOT_D);
  endfunction

  function automatic logic [1:0] slot_pos(input state_t s);
    case (s)
      SLOT_B:  return 2'd1;
      SLOT_C:  return 2'd2;
      SLOT_D:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic state_t pos_state(input logic [1:0] pos);
    case (pos)
      2'd1:    return SLOT_B;
      2'd2:    return SLOT_C;
      2'd3:    return SLOT_D;
      default: return SLOT_A;
    endcase
  endfunction

  // Idle slots are skipped without spending a cycle, so the next state is the
  // first slot position at or after 'start' that has a pending request.
  function automatic state_t first_active(input logic [2:0] start, input logic [3:0] pend,
                                          input logic prio);
    state_t ns;
    ns = SCAN;
    for (int p = 3; p >= 0; p--) begin
      if ((3'(p) >= start) && pend[kind_of(2'(p), prio)]) begin
        ns = pos_state(2'(p));
      end
    end
    return ns;
  endfunction

  // Latch player requests outside move slots and compute the next frame state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    pend_d   = pend_q;
    dir1_d   = dir1_q;
    dir2_d   = dir2_q;
    fdir1_d  = fdir1_q;
    fdir2_d  = fdir2_q;
    prio_d   = prio_q;
    in_slot  = is_slot(state_q);
    cur_pos  = slot_pos(state_q);
    cur_kind = kind_of(cur_pos, prio_q);

    if (!in_slot) begin
      if (p1_req) begin
        pend_d[0] = 1'b1;
        dir1_d    = p1_dir;
      end
      if (p1_fire) begin
        pend_d[1] = 1'b1;
        fdir1_d   = dir1_d;
      end
      if (p2_req) begin
        pend_d[2] = 1'b1;
        dir2_d    = p2_dir;
      end
      if (p2_fire) begin
        pend_d[3] = 1'b1;
        fdir2_d   = dir2_d;
      end
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = first_active(3'd0, pend_d, prio_q);
        end
      end
      SLOT_A, SLOT_B, SLOT_C, SLOT_D: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          state_d = first_active(3'(cur_pos) + 3'd1, pend_d, prio_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SCAN: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = DONE;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef STORAGE_SEQ_ROUND_ROBIN_EN
        prio_d = ~prio_q;
`else
        prio_d = prio_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    // A request is consumed as soon as its slot begins; later requests re-latch.
    if (is_slot(state_d) && (state_d != state_q)) begin
      pend_d[kind_of(slot_pos(state_d), prio_q)] = 1'b0;
    end
  end

  // Drive the storage control bus from the current state; quiet while in reset.
  always_comb begin
    st_mode     = 4'b0000;
    st_address  = '0;
    st_data     = '0;
    st_load_out = 1'b0;
    st_has_wall = 1'b0;
    wall_addr   = '0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    overrun     = 1'b0;
    slot_dir    = 2'd0;
    case (cur_kind)
      2'd0:    slot_dir = dir1_q;
      2'd1:    slot_dir = fdir1_q;
      2'd2:    slot_dir = dir2_q;
      default: slot_dir = fdir2_q;
    endcase
    if (reset) begin
      busy    = (state_q != IDLE) || tick;
      overrun = tick && (state_q != IDLE);
      case (state_q)
        SLOT_A, SLOT_B, SLOT_C, SLOT_D: begin
          st_mode     = {1'b0, cur_kind, 1'b1};
          st_data     = {6'b0, slot_dir};
          st_load_out = (cnt_q == LOAD_CYC);
        end
        SCAN: begin
          st_mode     = 4'b1111;
          st_address  = addr_q;
          wall_addr   = addr_q;
          st_has_wall = wall_q;
        end
        DONE: frame_done = 1'b1;
        default: ;
      endcase
    end
  end

  // State, counters and request latches, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      pend_q  <= '0;
      dir1_q  <= '0;
      dir2_q  <= '0;
      fdir1_q <= '0;
      fdir2_q <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      dir1_q  <= dir1_d;
      dir2_q  <= dir2_d;
      fdir1_q <= fdir1_d;
      fdir2_q <= fdir2_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_storage_sequencer.sv
// tb_storage_sequencer: randomized and directed stimulus against a frame-level
// reference model; expected storage events go into a scoreboard queue that a
// separate monitor drains whenever the sequencer drives the storage bus.
module tb_storage_sequencer;

  localparam int SLOT_LEN = 3;
  localparam int CELLS    = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       p1_req = 1'b0, p1_fire = 1'b0, p2_req = 1'b0, p2_fire = 1'b0;
  logic [1:0] p1_dir = 2'd0, p2_dir = 2'd0;
  logic       wall_q;
  logic [7:0] wall_addr, st_address, st_data;
  logic [3:0] st_mode;
  logic       st_load_out, st_has_wall, busy, frame_done, overrun;

  logic       wall_rom [CELLS];
  assign wall_q = wall_rom[wall_addr];

  typedef struct {
    int         cyc;
    logic [3:0] mode;
    logic [7:0] addr;
    logic [7:0] data;
    logic       load;
    logic       wall;
    logic       done;
  } ev_t;

  typedef struct {
    int   cyc;
    logic val;
  } busy_t;

  ev_t   evq[$];
  busy_t busyq[$];
  int    ovq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: what the players have requested and the current frame window.
  logic       m_pend [4];
  logic [1:0] m_dir  [2];
  logic [1:0] m_fdir [2];
  logic       m_prio = 1'b0;
  logic       f_valid = 1'b0;
  int         f_start = 0, f_n = 0, f_end = 0;

  storage_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .p1_req     (p1_req),
    .p1_dir     (p1_dir),
    .p1_fire    (p1_fire),
    .p2_req     (p2_req),
    .p2_dir     (p2_dir),
    .p2_fire    (p2_fire),
    .wall_q     (wall_q),
    .wall_addr  (wall_addr),
    .st_mode    (st_mode),
    .st_address (st_address),
    .st_data    (st_data),
    .st_load_out(st_load_out),
    .st_has_wall(st_has_wall),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mode_code(input int k);
    case (k)
      0:       return 4'b0001;
      1:       return 4'b0011;
      2:       return 4'b0101;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [1:0] kind_dir(input int k);
    case (k)
      0:       return m_dir[0];
      1:       return m_fdir[0];
      2:       return m_dir[1];
      default: return m_fdir[1];
    endcase
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_dir[0]  = 2'd0;
    m_dir[1]  = 2'd0;
    m_fdir[0] = 2'd0;
    m_fdir[1] = 2'd0;
    m_prio    = 1'b0;
    f_valid   = 1'b0;
  endtask

  // Build the whole frame's expected event list at the tick that starts it.
  task automatic startFrame();
    int order[4];
    int n;
    ev_t e;
    if (m_prio) begin
      order[0] = 2; order[1] = 3; order[2] = 0; order[3] = 1;
    end else begin
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3;
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_pend[order[i]]) begin
        for (int s = 0; s < SLOT_LEN; s++) begin
          e.cyc  = cyc + 1 + SLOT_LEN * n + s;
          e.mode = mode_code(order[i]);
          e.addr = 8'd0;
          e.data = {6'b0, kind_dir(order[i])};
          e.load = (s == 1);
          e.wall = 1'b0;
          e.done = 1'b0;
          evq.push_back(e);
        end
        m_pend[order[i]] = 1'b0;
        n++;
      end
    end
    for (int a = 0; a < CELLS; a++) begin
      e.cyc  = cyc + 1 + SLOT_LEN * n + a;
      e.mode = 4'b1111;
      e.addr = 8'(a);
      e.data = 8'd0;
      e.load = 1'b0;
      e.wall = wall_rom[a];
      e.done = 1'b0;
      evq.push_back(e);
    end
    e.cyc  = cyc + SLOT_LEN * n + CELLS + 1;
    e.mode = 4'b0000;
    e.addr = 8'd0;
    e.data = 8'd0;
    e.load = 1'b0;
    e.wall = 1'b0;
    e.done = 1'b1;
    evq.push_back(e);
    f_valid = 1'b1;
    f_start = cyc;
    f_n     = n;
    f_end   = e.cyc;
`ifdef STORAGE_SEQ_ROUND_ROBIN_EN
    m_prio = ~m_prio;
`endif
  endtask

  // Drive one cycle of inputs and advance the reference model for that cycle.
  task automatic applyStimulus(input logic t, input logic r1, input logic [1:0] d1, input logic f1,
                               input logic r2, input logic [1:0] d2, input logic f2,
                               input logic rn);
    logic in_slot;
    logic fbusy;
    busy_t b;
    @(posedge clk);
    #1;
    cyc++;
    reset = rn; tick = t;
    p1_req = r1; p1_dir = d1; p1_fire = f1;
    p2_req = r2; p2_dir = d2; p2_fire = f2;
    if (!rn) begin
      evq.delete();
      ovq.delete();
      busyq.delete();
      clearModel();
      return;
    end
    in_slot = f_valid && (cyc > f_start) && (cyc <= f_start + SLOT_LEN * f_n);
    if (!in_slot) begin
      if (r1) begin m_pend[0] = 1'b1; m_dir[0] = d1; end
      if (f1) begin m_pend[1] = 1'b1; m_fdir[0] = m_dir[0]; end
      if (r2) begin m_pend[2] = 1'b1; m_dir[1] = d2; end
      if (f2) begin m_pend[3] = 1'b1; m_fdir[1] = m_dir[1]; end
    end
    fbusy = f_valid && (cyc >= f_start) && (cyc <= f_end);
    if (t) begin
      if (fbusy) ovq.push_back(cyc);
      else startFrame();
    end
    b.cyc = cyc;
    b.val = f_valid && (cyc >= f_start) && (cyc <= f_end);
    busyq.push_back(b);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, 0, 0, 2'd0, 0, 1);
  endtask

  task automatic checkOutput(input ev_t e);
    checks++;
    if (st_mode !== e.mode || st_address !== e.addr || wall_addr !== e.addr ||
        st_data !== e.data || st_load_out !== e.load || st_has_wall !== e.wall ||
        frame_done !== e.done) begin
      errors++;
      $display("[TB] FAIL storage_event cyc=%0d got mode=%b addr=%0d waddr=%0d data=%h load=%0b wall=%0b done=%0b required mode=%b addr=%0d data=%h load=%0b wall=%0b done=%0b",
               cyc, st_mode, st_address, wall_addr, st_data, st_load_out, st_has_wall, frame_done,
               e.mode, e.addr, e.data, e.load, e.wall, e.done);
    end
  endtask

  // Monitor: drains the scoreboard whenever the storage bus is active.
  initial begin : monitor
    ev_t   e;
    busy_t b;
    logic  present;
    logic  exp_ov;
    forever begin
      @(negedge clk);
      if (reset) begin
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
          e = evq.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL missing_event cyc=%0d got idle bus required mode=%b addr=%0d done=%0b at cycle %0d",
                   cyc, e.mode, e.addr, e.done, e.cyc);
        end
        present = (st_mode != 4'b0000) || st_load_out || frame_done || (st_address != 8'd0) ||
                  (st_data != 8'd0) || st_has_wall || (wall_addr != 8'd0);
        if (present) begin
          if (evq.size() > 0 && evq[0].cyc == cyc) begin
            checkOutput(evq.pop_front());
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output cyc=%0d got mode=%b addr=%0d data=%h load=%0b done=%0b required idle bus",
                     cyc, st_mode, st_address, st_data, st_load_out, frame_done);
          end
        end
        if (busyq.size() > 0 && busyq[0].cyc == cyc) begin
          b = busyq.pop_front();
          checks++;
          if (busy !== b.val) begin
            errors++;
            $display("[TB] FAIL busy cyc=%0d got %0b required %0b", cyc, busy, b.val);
          end
        end
        exp_ov = (ovq.size() > 0) && (ovq[0] == cyc);
        if (exp_ov) void'(ovq.pop_front());
        checks++;
        if (overrun !== exp_ov) begin
          errors++;
          $display("[TB] FAIL overrun cyc=%0d got %0b required %0b", cyc, overrun, exp_ov);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic, then drain.
  initial begin : stimulus
    for (int i = 0; i < CELLS; i++) wall_rom[i] = 1'($urandom_range(0, 1));
    clearModel();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'd0, 0, 0, 2'd0, 0, 0);
    idleCycles(3);

    $display("[TB] empty frame");
    applyStimulus(1, 0, 2'd0, 0, 0, 2'd0, 0, 1);
    idleCycles(262);

    $display("[TB] tank1 move right");
    applyStimulus(0, 1, 2'd3, 0, 0, 2'd0, 0, 1);
    applyStimulus(1, 0, 2'd0, 0, 0, 2'd0, 0, 1);
    idleCycles(265);

    $display("[TB] both tanks, two frames");
    applyStimulus(1, 1, 2'd1, 0, 1, 2'd0, 0, 1);
    for (int i = 0; i < 270; i++) applyStimulus(0, 1, 2'd1, 0, 1, 2'd0, 0, 1);
    applyStimulus(1, 1, 2'd1, 0, 1, 2'd0, 0, 1);
    idleCycles(270);

    $display("[TB] held and released fire");
    applyStimulus(1, 0, 2'd0, 1, 0, 2'd0, 0, 1);
    for (int i = 0; i < 265; i++) applyStimulus(0, 0, 2'd0, 1, 0, 2'd0, 0, 1);
    applyStimulus(1, 0, 2'd0, 0, 0, 2'd0, 0, 1);
    idleCycles(265);
    applyStimulus(1, 0, 2'd0, 0, 0, 2'd0, 0, 1);
    idleCycles(262);

    $display("[TB] tick during scan");
    applyStimulus(1, 0, 2'd0, 0, 0, 2'd0, 0, 1);
    idleCycles(100);
    applyStimulus(1, 0, 2'd0, 0, 0, 2'd0, 0, 1);
    idleCycles(200);

    $display("[TB] reset mid scan");
    applyStimulus(1, 0, 2'd0, 0, 0, 2'd0, 0, 1);
    for (int i = 0; i < 50; i++) applyStimulus(0, 1, 2'd2, 1, 0, 2'd0, 0, 1);
    applyStimulus(0, 0, 2'd0, 0, 0, 2'd0, 0, 0);
    idleCycles(5);
    applyStimulus(1, 0, 2'd0, 0, 0, 2'd0, 0, 1);
    idleCycles(262);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 5000; i++) begin
      applyStimulus(($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 2999) != 0));
    end
    idleCycles(300);

    checks++;
    if (evq.size() != 0 || ovq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d events and %0d overruns pending required 0 and 0",
               evq.size(), ovq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
